// File: rtl/mem_access_ctrl.sv
// Splits 32-bit MEM-stage loads/stores into two wait-stretched 16-bit SRAM accesses, low half first.
// Optional posted stores: define MEM_CTRL_POSTED_WRITE_EN.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] st_val,
  output logic [31:0] rd_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        is_wr_q;
  logic [15:0] st_hi_q;
  logic [31:0] rd_data_q;
  logic [17:0] sram_addr_q;
  logic [15:0] dq_out_q;
  logic        dq_oe_q;
  logic        we_n_q;

  logic        req;
  logic [16:0] word_idx;
  logic        posted_wr;

  assign req      = rd_en | wr_en;
  assign word_idx = 17'((address - ADDR_BASE) >> 2);

`ifdef MEM_CTRL_POSTED_WRITE_EN
  assign posted_wr = is_wr_q;
`else
  assign posted_wr = 1'b0;
`endif

  // Handshake: the pipeline holds rd_en/wr_en (and operands) as a level until it
  // sees ready=1; ready=0 freezes IF..MEM. A request is consumed in the cycle
  // ready is 1 while it is asserted, and is never replayed from DONE.
  always_comb begin
    ready = 1'b0;
    unique case (state_q)
`ifdef MEM_CTRL_POSTED_WRITE_EN
      S_IDLE:  ready = wr_en | ~rd_en;
`else
      S_IDLE:  ready = ~req;
`endif
      S_DONE:  ready = 1'b1;
      default: ready = ~req;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      is_wr_q     <= 1'b0;
      st_hi_q     <= 16'd0;
      rd_data_q   <= 32'd0;
      sram_addr_q <= 18'd0;
      dq_out_q    <= 16'd0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            // Write wins when both are asserted; operands are frozen here.
            state_q     <= S_LOW;
            cnt_q       <= CNT_LOAD;
            is_wr_q     <= wr_en;
            st_hi_q     <= st_val[31:16];
            sram_addr_q <= {word_idx, 1'b0};
            dq_out_q    <= st_val[15:0];
            dq_oe_q     <= wr_en;
            we_n_q      <= ~wr_en;
          end
        end
        S_LOW: begin
          if (cnt_q == 4'd0) begin
            if (!is_wr_q) rd_data_q[15:0] <= sram_dq_in;
            state_q        <= S_HIGH;
            cnt_q          <= CNT_LOAD;
            sram_addr_q[0] <= 1'b1;
            dq_out_q       <= st_hi_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_HIGH: begin
          if (cnt_q == 4'd0) begin
            if (!is_wr_q) rd_data_q[31:16] <= sram_dq_in;
            dq_oe_q <= 1'b0;
            we_n_q  <= 1'b1;
            state_q <= posted_wr ? S_IDLE : S_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_data     = rd_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a W=3 and a W=1 instance, each on its own SRAM model,
// checked against a word-level memory model.
module tb_mem_access_ctrl;

  localparam int unsigned W0   = 3;
  localparam int unsigned W1   = 1;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk;
  logic        rst;
  logic        rd_en     [2];
  logic        wr_en     [2];
  logic [31:0] address   [2];
  logic [31:0] st_val    [2];
  logic [31:0] rd_data   [2];
  logic        ready     [2];
  logic [17:0] sram_addr [2];
  logic [15:0] dq_out    [2];
  logic [15:0] dq_in     [2];
  logic        dq_oe     [2];
  logic        we_n      [2];
  logic [1:0]  dbg_state [2];

  logic [15:0] sram     [2][256];
  logic [31:0] ref_word [2][128];
  logic [31:0] exp_rd   [2];
  int          t_rdy    [2];
  bit          mem_init = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  mem_access_ctrl #(.WAIT_CYCLES(W0), .ADDR_BASE(BASE)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en[0]), .rd_en(rd_en[0]), .address(address[0]),
    .st_val(st_val[0]), .rd_data(rd_data[0]), .ready(ready[0]), .sram_addr(sram_addr[0]),
    .sram_dq_out(dq_out[0]), .sram_dq_oe(dq_oe[0]), .sram_dq_in(dq_in[0]),
    .sram_we_n(we_n[0]), .dbg_state(dbg_state[0])
  );

  mem_access_ctrl #(.WAIT_CYCLES(W1), .ADDR_BASE(BASE)) u_dut_w1 (
    .clk(clk), .rst(rst), .wr_en(wr_en[1]), .rd_en(rd_en[1]), .address(address[1]),
    .st_val(st_val[1]), .rd_data(rd_data[1]), .ready(ready[1]), .sram_addr(sram_addr[1]),
    .sram_dq_out(dq_out[1]), .sram_dq_oe(dq_oe[1]), .sram_dq_in(dq_in[1]),
    .sram_we_n(we_n[1]), .dbg_state(dbg_state[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  function automatic logic [15:0] init_half(input int k, input int i);
    return 16'((i * 40503) ^ (k * 1234) ^ 32'h5a00);
  endfunction

  // SRAM models: asynchronous read, write strobed at the clock edge.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 256; i++) sram[k][i] = init_half(k, i);
      mem_init = 1'b1;
    end
    for (int k = 0; k < 2; k++)
      if (we_n[k] == 1'b0) sram[k][sram_addr[k][7:0]] = dq_out[k];
  end
  assign dq_in[0] = sram[0][sram_addr[0][7:0]];
  assign dq_in[1] = sram[1][sram_addr[1][7:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Driver: called just after a rising edge; that cycle is cycle 0 of the request.
  // Returns just after the rising edge that starts the cycle after completion.
  task automatic access(input int k, input bit wr, input bit rd,
                        input logic [31:0] addr, input logic [31:0] data);
    int          wc;
    logic [16:0] w;
    logic [6:0]  wi;
    bit          posted;
    bit          hi;
    wc = (k == 0) ? int'(W0) : int'(W1);
    w  = 17'((addr - BASE) >> 2);
    wi = w[6:0];
    posted = 1'b0;
`ifdef MEM_CTRL_POSTED_WRITE_EN
    posted = wr;
`endif
    wr_en[k] = wr; rd_en[k] = rd; address[k] = addr; st_val[k] = data;
    @(negedge clk);
    check("ready_c0", 32'(ready[k]), 32'(posted));
    for (int c = 1; c <= 2 * wc + 1; c++) begin
      @(posedge clk); #1;
      address[k] = $urandom;
      st_val[k]  = $urandom;
      if (posted) begin wr_en[k] = 1'b0; rd_en[k] = 1'b0; end
      @(negedge clk);
      check("ready", 32'(ready[k]), 32'(posted || c == 2 * wc + 1));
      if (c <= 2 * wc) begin
        hi = (c > wc);
        check("sram_addr", 32'(sram_addr[k]), 32'({w, hi}));
        check("sram_we_n", 32'(we_n[k]), 32'(!wr));
        check("sram_dq_oe", 32'(dq_oe[k]), 32'(wr));
        if (wr) check("sram_dq_out", 32'(dq_out[k]), hi ? 32'(data[31:16]) : 32'(data[15:0]));
      end
    end
    t_rdy[k] = cyc;
    if (wr) ref_word[k][wi] = data;
    else if (rd) exp_rd[k] = ref_word[k][wi];
    check("rd_data", rd_data[k], exp_rd[k]);
    if (wr) begin
      check("sram_lo", 32'(sram[k][{wi, 1'b0}]), 32'(ref_word[k][wi][15:0]));
      check("sram_hi", 32'(sram[k][{wi, 1'b1}]), 32'(ref_word[k][wi][31:16]));
    end
    @(posedge clk); #1;
    wr_en[k] = 1'b0; rd_en[k] = 1'b0;
  endtask

  initial begin
    int          op;
    int          lat;
    int          prev;
    logic [31:0] a;

    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rd_en[k] = 1'b0; wr_en[k] = 1'b0; address[k] = '0; st_val[k] = '0;
      exp_rd[k] = '0; t_rdy[k] = 0;
      for (int i = 0; i < 128; i++)
        ref_word[k][i] = {init_half(k, 2 * i + 1), init_half(k, 2 * i)};
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_ready", 32'(ready[k]), 32'd1);
      check("rst_rd_data", rd_data[k], 32'd0);
      check("rst_sram_addr", 32'(sram_addr[k]), 32'd0);
      check("rst_dq_out", 32'(dq_out[k]), 32'd0);
      check("rst_dq_oe", 32'(dq_oe[k]), 32'd0);
      check("rst_we_n", 32'(we_n[k]), 32'd1);
      check("rst_state_idle", 32'(dbg_state[k]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed cases from the block's usage scenarios.
    access(0, 1'b1, 1'b0, BASE + 32'd4, 32'h1234_BEEF);
    check("plan_half2", 32'(sram[0][2]), 32'h0000_BEEF);
    check("plan_half3", 32'(sram[0][3]), 32'h0000_1234);
    access(0, 1'b0, 1'b1, BASE + 32'd4, 32'h0);
    check("plan_rd_word", rd_data[0], 32'h1234_BEEF);
    access(0, 1'b1, 1'b0, BASE, 32'hCAFE_F00D);
    access(0, 1'b1, 1'b1, BASE + 32'd8, 32'h0BAD_F00D);
    check("both_high_rd_kept", rd_data[0], 32'h1234_BEEF);
    access(0, 1'b0, 1'b1, BASE - 32'd4, 32'h0);
    access(0, 1'b0, 1'b1, BASE + 32'd10, 32'h0);
    check("read_after_both", rd_data[0], 32'h0BAD_F00D);

`ifdef MEM_CTRL_POSTED_WRITE_EN
    wr_en[0] = 1'b1; rd_en[0] = 1'b0; address[0] = BASE + 32'd36; st_val[0] = 32'h600D_CAFE;
    @(negedge clk);
    check("posted_ready_c0", 32'(ready[0]), 32'd1);
    @(posedge clk); #1;
    wr_en[0] = 1'b0; rd_en[0] = 1'b1;
    ref_word[0][9] = 32'h600D_CAFE;
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (ready[0] === 1'b1) lat = c;
      else begin @(posedge clk); #1; end
    end
    check("posted_read_latency", 32'(lat), 32'd14);
    exp_rd[0] = ref_word[0][9];
    check("posted_rd_data", rd_data[0], exp_rd[0]);
    @(posedge clk); #1;
    rd_en[0] = 1'b0;
`endif

    // Reset in cycle 3 of a store: low half already written, high half untouched.
    wr_en[0] = 1'b1; rd_en[0] = 1'b0; address[0] = BASE + 32'd20; st_val[0] = 32'hA5A5_5A5A;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; wr_en[0] = 1'b0;
    ref_word[0][5][15:0] = 16'h5A5A;
    exp_rd[0] = '0; exp_rd[1] = '0;
    @(negedge clk);
    check("abort_we_n", 32'(we_n[0]), 32'd1);
    check("abort_dq_oe", 32'(dq_oe[0]), 32'd0);
    check("abort_rd_data", rd_data[0], 32'd0);
    check("abort_ready", 32'(ready[0]), 32'd1);
    check("abort_w1_rd_data", rd_data[1], 32'd0);
    check("abort_sram_lo", 32'(sram[0][10]), 32'(ref_word[0][5][15:0]));
    check("abort_sram_hi", 32'(sram[0][11]), 32'(ref_word[0][5][31:16]));
    @(posedge clk); #1;

    // Randomized traffic on the W=3 instance.
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 2));
      a  = BASE + 32'(4 * $urandom_range(0, 127)) + 32'($urandom_range(0, 3));
      access(0, op != 0, op != 1, a, $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // W=1 instance: one store, then back-to-back loads every 4 cycles.
    access(1, 1'b1, 1'b0, BASE + 32'd12, $urandom);
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      a = (i == 0) ? BASE + 32'd12 : BASE + 32'(4 * $urandom_range(0, 127));
      access(1, 1'b0, 1'b1, a, 32'h0);
      if (prev >= 0) check("w1_b2b_spacing", 32'(t_rdy[1] - prev), 32'd4);
      prev = t_rdy[1];
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle controller that places the MEM stage's 32-bit loads and stores on an external 16-bit-wide SRAM. Each word is split into two half-word accesses, low half first, and each half is stretched over a configurable number of wait cycles. `ready` is driven back to the pipeline so the hazard/freeze logic can stall IF through MEM while an access is in flight. The block sits between the MEM stage and the SRAM pins and replaces the single-cycle data memory.

## Interface
Parameters:
- `WAIT_CYCLES`, default 3: cycles per half-word access; legal range 1–15.
- `ADDR_BASE`, default 1024: byte offset subtracted from the pipeline address before mapping.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  store request from MEM stage; level, held until `ready`.
- `rd_en`  in  1  load request from MEM stage; level, held until `ready`.
- `address`  in  32  byte address from the ALU result.
- `st_val`  in  32  store data.
- `rd_data`  out  32  load result; valid while `ready`=1 in DONE, held afterwards.
- `ready`  out  1  combinational; 0 means freeze the pipeline.
- `sram_addr`  out  18  half-word address.
- `sram_dq_out`  out  16  write data.
- `sram_dq_oe`  out  1  1 while driving the bus.
- `sram_dq_in`  in  16  read data.
- `sram_we_n`  out  1  active-low write strobe.

## Operation
- Word index: `w = (address - ADDR_BASE) >> 2`, 17 bits, upper bits dropped. Low half uses `sram_addr = {w,1'b0}`; high half uses `{w,1'b1}`.
- `wr_en` and `rd_en` both high: the request is a write.
- Address, data and op are latched on leaving IDLE and are not re-sampled during the access.
- IDLE: on a request go to LOW and load the counter with `WAIT_CYCLES-1`.
- LOW: drive the low half-address. On a write, drive `st_val[15:0]` with `sram_dq_oe`=1 and `sram_we_n`=0. On a read, capture `sram_dq_in` into `rd_data[15:0]` when the counter reaches 0. Go to HIGH when the counter reaches 0.
- HIGH: same as LOW, using bits [31:16]. Go to DONE when the counter reaches 0.
- DONE: one cycle, then IDLE unconditionally. The still-asserted request is not restarted.
- `ready`: equals `!(rd_en|wr_en)` in IDLE, 1 in DONE, and 0 in LOW/HIGH while a request is present.
- Reset values, applied at the first `clk` edge with `rst`=0: state IDLE, counter 0, `rd_data`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1.
- Reset mid-access aborts immediately. A partial SRAM write is not rolled back.

## Timing
- Request first seen at cycle 0. LOW occupies cycles 1..W, HIGH occupies W+1..2W, DONE is cycle 2W+1.
- `ready` is 0 for 2W+1 cycles, then 1 in DONE. With the default W=3, `ready` rises 7 cycles after the request.
- W=1: LOW and HIGH last one cycle each; DONE at cycle 3.
- `sram_we_n` is low for exactly W cycles per half, on consecutive cycles, with no gap between halves.
- Back-to-back requests: the next one is recognised in the IDLE cycle following DONE. Minimum spacing is 2W+2 cycles.

## Configuration
- `MEM_CTRL_POSTED_WRITE_EN` defined:
  - A write seen in IDLE makes `ready`=1 in that same cycle, so the pipeline proceeds without stalling.
  - The LOW/HIGH sequence runs in the background and returns from HIGH directly to IDLE, skipping DONE.
  - Any request arriving while a posted write is busy sees `ready`=0 until the write finishes, then is processed normally from IDLE.
  - Reads are unchanged.
- `MEM_CTRL_POSTED_WRITE_EN` undefined: writes stall exactly like reads, as described above.

## Test plan
- Reset, then W=3, `rd_en`=1, `address`=1028, SRAM model holding 0xBEEF at half-address 2 and 0x1234 at half-address 3:
  - `sram_addr` is 2 in cycles 1–3 and 3 in cycles 4–6.
  - `ready`=1 in cycle 7 with `rd_data`=0x1234BEEF.
- `wr_en`=1, `address`=1024, `st_val`=0xCAFEF00D:
  - `sram_we_n`=0 for cycles 1–6.
  - `sram_dq_out` is 0xF00D then 0xCAFE.
  - `ready` rises in cycle 7.
- `rd_en` and `wr_en` both high: a write occurs and `rd_data` is unchanged.
- `rst`=0 in cycle 3 of a write: the next cycle is IDLE, `sram_we_n`=1, `sram_dq_oe`=0, `rd_data`=0.
- With `MEM_CTRL_POSTED_WRITE_EN` defined:
  - A write gets `ready`=1 in cycle 0.
  - A read issued in cycle 1 sees `ready`=0 until the write finishes at cycle 6; its IDLE pass is at cycle 7 and `ready` rises at cycle 14.
- W=1: `ready` returns in cycle 3, and back-to-back reads complete every 4 cycles.
